instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter and an internal loadable instruction memory, and drives the IF/ID pipeline register. Outputs: the fetched instruction and PC+4, which decode consumes unchanged. Handles hazard stalls, branch/jump redirects with a one-slot flush, halt detection, and program loading by the debug unit.

## Interface
- `len`, 32, datapath width (instruction, PC)
- `ram_depth`, 256, instruction memory depth in 32-bit words
- `NA`, `$clog2(ram_depth)`, word-address width
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  reset, synchronous and active-high
- `in_enable`  in  1  run/step enable from debug unit; low holds the whole stage
- `in_stall`  in  1  load-use hazard hold from hazard unit
- `in_branch_taken`  in  1  taken branch resolved downstream
- `in_branch_target`  in  len  branch target byte address
- `in_jump`  in  1  jump resolved downstream
- `in_jump_target`  in  len  jump target byte address
- `in_load_en`  in  1  instruction memory write strobe
- `in_load_addr`  in  NA  word address for load
- `in_load_data`  in  len  instruction word to load
- `out_pc`  out  len  byte address of the instruction in IF/ID
- `out_pc_jump`  out  len  out_pc + 4, feeds decode
- `out_instruccion`  out  len  instruction in IF/ID, feeds decode
- `out_halt`  out  1  the instruction in IF/ID is HALT

## Operation
- Internal state: `pc` (len bits), `halted` flag, IF/ID registers (the four outputs), memory array `imem[ram_depth]`.
- Memory read is combinational: `imem[pc[NA+1:2]]`. The word index wraps modulo ram_depth. pc[1:0] are ignored.
- Memory write is synchronous: on the edge where in_load_en=1, `imem[in_load_addr] <= in_load_data`. The write is independent of the other controls.
- imem is not cleared by reset. The debug unit loads the program, then pulses reset.
- A pc update is allowed on an edge when in_enable=1 and in_load_en=0; call this "active".
- Per-edge priority, highest first:
  - reset: pc=0, halted=0, IF/ID=NOP.
  - Not active: everything holds.
  - in_branch_taken=1: pc <= in_branch_target, IF/ID <= NOP, halted <= 0.
  - in_jump=1: pc <= in_jump_target, IF/ID <= NOP, halted <= 0. Branch wins over jump because the branch comes from the older instruction.
  - in_stall=1: pc and IF/ID hold.
  - halted=1: pc holds, IF/ID <= NOP.
  - Normal: IF/ID <= {pc, pc+4, imem word, halt_detect}, pc <= pc+4.
- In the normal case, when the fetched word has opcode [31:26]=6'b111111, halt_detect=1. halted is set on the same edge and pc holds (it is not incremented).
- NOP is out_instruccion=32'h0000_0000, out_pc=0, out_pc_jump=0, out_halt=0.
- PC arithmetic is len-bit modulo 2^len; 32'hFFFF_FFFC + 4 = 0.
- A redirect clears halted, because a HALT fetched behind a taken branch is wrong-path.

## Timing
- Reset values: out_pc=0, out_pc_jump=0, out_instruccion=0, out_halt=0, internal pc=0, halted=0.
- Fetch latency is one cycle. The word at pc appears on the IF/ID outputs after the next active edge.
- Redirect asserted before edge N:
  - After edge N: IF/ID=NOP, pc=target.
  - After edge N+1: IF/ID holds the target instruction, with out_pc_jump=target+4.
- Stall or enable low: the outputs stay bit-identical for every cycle it is held. Decode sees no bubble and no duplicate.
- Stall and redirect together: the redirect wins, and the flush NOP replaces the stalled instruction.
- in_load_en during operation: the stage holds that cycle. A write to the address currently at pc is visible on the next active edge.
- HALT fetched at edge N:
  - After edge N: out_halt=1.
  - After edge N+1: out_halt=0 and NOPs follow indefinitely, with pc frozen at the HALT address, until reset or a redirect.
- Control inputs are sampled only at the rising edge. There are no combinational paths from inputs to outputs.

## Test plan
- Sequential fetch: load 0x20010005, 0x20020007, 0x00221820 at words 0–2, pulse reset. After edges 1, 2, 3 expect out_pc=0/4/8, out_pc_jump=4/8/12, out_instruccion equal to each word in order.
- Stall: assert in_stall for 3 cycles while out_pc=4. Outputs stay at pc 4 / 0x20020007 for all 3 cycles. The edge after release shows pc 8.
- Redirect priority: with out_pc=8, assert in_branch_taken (target 0x40) and in_jump (target 0x80) together. Next edge: out_instruccion=0. Following edge: out_pc=0x40, out_pc_jump=0x44. Repeat with in_stall also high; the result is the same.
- Halt: place 0xFC000000 at word 3. Expect out_halt=1 with out_pc=12 for one cycle, then NOPs for at least 10 cycles. After reset, fetch restarts at pc 0.
- Enable/load hold: deassert in_enable for 5 cycles, then assert in_load_en for 1 cycle writing word 5. Outputs are unchanged throughout. Memory readback at word 5 is correct when fetched.
- Wrap: with ram_depth=256, a jump to 0x400 fetches word 0; a jump to 0xFFFF_FFFC yields out_pc_jump=0.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: program counter, loadable instruction memory and IF/ID register.
// Redirects flush one slot; a fetched HALT freezes the PC until reset or a redirect.
module instruction_fetch #(
  parameter int unsigned len       = 32,
  parameter int unsigned ram_depth = 256,
  parameter int unsigned NA        = $clog2(ram_depth)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_enable,
  input  logic          in_stall,
  input  logic          in_branch_taken,
  input  logic [len-1:0] in_branch_target,
  input  logic          in_jump,
  input  logic [len-1:0] in_jump_target,
  input  logic          in_load_en,
  input  logic [NA-1:0] in_load_addr,
  input  logic [len-1:0] in_load_data,
  output logic [len-1:0] out_pc,
  output logic [len-1:0] out_pc_jump,
  output logic [len-1:0] out_instruccion,
  output logic          out_halt
);

  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  logic [len-1:0] imem [ram_depth];

  logic [len-1:0] pc_q,          pc_d;
  logic           halted_q,      halted_d;
  logic [len-1:0] ifid_pc_q,     ifid_pc_d;
  logic [len-1:0] ifid_pcj_q,    ifid_pcj_d;
  logic [len-1:0] ifid_instr_q,  ifid_instr_d;
  logic           ifid_halt_q,   ifid_halt_d;

  logic           active_c;
  logic [NA-1:0]  rd_addr_c;
  logic [len-1:0] rd_word_c;
  logic [len-1:0] pc_plus4_c;
  logic           halt_det_c;

  // Loading the memory takes priority over fetching in the same cycle.
  assign active_c   = in_enable & ~in_load_en;
  assign rd_addr_c  = pc_q[NA+1:2];
  assign rd_word_c  = imem[rd_addr_c];
  assign pc_plus4_c = pc_q + len'(4);
  assign halt_det_c = (rd_word_c[len-1:len-6] == HALT_OPCODE);

  // Next-state selection, highest priority first.
  always_comb begin
    pc_d         = pc_q;
    halted_d     = halted_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pcj_d   = ifid_pcj_q;
    ifid_instr_d = ifid_instr_q;
    ifid_halt_d  = ifid_halt_q;

    if (active_c) begin
      if (in_branch_taken || in_jump) begin
        // Branch beats jump: it comes from the older instruction.
        pc_d         = in_branch_taken ? in_branch_target : in_jump_target;
        halted_d     = 1'b0;
        ifid_pc_d    = '0;
        ifid_pcj_d   = '0;
        ifid_instr_d = '0;
        ifid_halt_d  = 1'b0;
      end else if (in_stall) begin
        pc_d = pc_q;
      end else if (halted_q) begin
        ifid_pc_d    = '0;
        ifid_pcj_d   = '0;
        ifid_instr_d = '0;
        ifid_halt_d  = 1'b0;
      end else begin
        ifid_pc_d    = pc_q;
        ifid_pcj_d   = pc_plus4_c;
        ifid_instr_d = rd_word_c;
        ifid_halt_d  = halt_det_c;
        halted_d     = halt_det_c;
        pc_d         = halt_det_c ? pc_q : pc_plus4_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= '0;
      halted_q     <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_pcj_q   <= '0;
      ifid_instr_q <= '0;
      ifid_halt_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      halted_q     <= halted_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pcj_q   <= ifid_pcj_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_halt_q  <= ifid_halt_d;
    end
  end

  // Memory contents survive reset so a loaded program can be restarted.
  always_ff @(posedge clk) begin
    if (in_load_en) begin
      imem[in_load_addr] <= in_load_data;
    end
  end

  assign out_pc          = ifid_pc_q;
  assign out_pc_jump     = ifid_pcj_q;
  assign out_instruccion = ifid_instr_q;
  assign out_halt        = ifid_halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed program plus random control traffic,
// checked cycle by cycle against a queued reference-model expectation.
module tb_instruction_fetch;

  localparam int unsigned LEN   = 32;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned NA    = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcj;
    logic [31:0] ins;
    logic        halt;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          in_enable;
  logic          in_stall;
  logic          in_branch_taken;
  logic [31:0]   in_branch_target;
  logic          in_jump;
  logic [31:0]   in_jump_target;
  logic          in_load_en;
  logic [NA-1:0] in_load_addr;
  logic [31:0]   in_load_data;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_jump;
  logic [31:0]   out_instruccion;
  logic          out_halt;

  instruction_fetch #(.len(LEN), .ram_depth(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_enable        (in_enable),
    .in_stall         (in_stall),
    .in_branch_taken  (in_branch_taken),
    .in_branch_target (in_branch_target),
    .in_jump          (in_jump),
    .in_jump_target   (in_jump_target),
    .in_load_en       (in_load_en),
    .in_load_addr     (in_load_addr),
    .in_load_data     (in_load_data),
    .out_pc           (out_pc),
    .out_pc_jump      (out_pc_jump),
    .out_instruccion  (out_instruccion),
    .out_halt         (out_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: program memory, fetch pointer, frozen flag, IF/ID view.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc;
  logic        m_halted;
  exp_t        m_out;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t got %h expected %h", nm, $time, got, want);
    end
  endtask

  // Monitor: one expectation per clock edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_pc",          out_pc,              e.pc);
        check("out_pc_jump",     out_pc_jump,         e.pcj);
        check("out_instruccion", out_instruccion,     e.ins);
        check("out_halt",        {31'd0, out_halt},   {31'd0, e.halt});
      end
    end
  end

  task automatic model_edge(input logic rst, input logic en, input logic stl,
                            input logic br, input logic [31:0] bt,
                            input logic jp, input logic [31:0] jt,
                            input logic ld, input logic [7:0] la, input logic [31:0] ldd);
    logic [31:0] word;
    logic        is_halt;
    word    = m_mem[m_pc[9:2]];
    is_halt = (word[31:26] == 6'h3f);
    if (rst) begin
      m_pc = 0; m_halted = 0; m_out = '0;
    end else if (en && !ld) begin
      if (br) begin
        m_pc = bt; m_halted = 0; m_out = '0;
      end else if (jp) begin
        m_pc = jt; m_halted = 0; m_out = '0;
      end else if (stl) begin
        m_out = m_out;
      end else if (m_halted) begin
        m_out = '0;
      end else begin
        m_out.pc   = m_pc;
        m_out.pcj  = m_pc + 32'd4;
        m_out.ins  = word;
        m_out.halt = is_halt;
        if (is_halt) m_halted = 1;
        else         m_pc = m_pc + 32'd4;
      end
    end
    if (ld) m_mem[la] = ldd;
  endtask

  task automatic drive(input logic rst, input logic en, input logic stl,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt,
                       input logic ld, input logic [7:0] la, input logic [31:0] ldd);
    @(negedge clk);
    reset = rst; in_enable = en; in_stall = stl;
    in_branch_taken = br; in_branch_target = bt;
    in_jump = jp; in_jump_target = jt;
    in_load_en = ld; in_load_addr = la; in_load_data = ldd;
    model_edge(rst, en, stl, br, bt, jp, jt, ld, la, ldd);
    sb.push_back(m_out);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    drive(0, 0, 0, 0, 0, 0, 0, 1, a, d);
  endtask

  function automatic logic [31:0] rand_plain();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3f) w[31:26] = 6'h08;
    return w;
  endfunction

  initial begin
    logic [31:0] bt, jt, ldd;
    reset = 1; in_enable = 0; in_stall = 0; in_branch_taken = 0; in_branch_target = 0;
    in_jump = 0; in_jump_target = 0; in_load_en = 0; in_load_addr = 0; in_load_data = 0;
    m_pc = 0; m_halted = 0; m_out = '0;

    pulse_reset();
    for (int i = 0; i < 256; i++) load_word(8'(i), rand_plain());
    load_word(0, 32'h2001_0005);
    load_word(1, 32'h2002_0007);
    load_word(2, 32'h0022_1820);
    load_word(3, 32'h0000_0020);

    // Sequential fetch, stall, then combined branch/jump redirect.
    pulse_reset();
    run(2);
    repeat (3) drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    run(1);
    drive(0, 1, 0, 1, 32'h40, 1, 32'h80, 0, 0, 0);
    run(2);
    pulse_reset();
    run(3);
    drive(0, 1, 1, 1, 32'h40, 1, 32'h80, 0, 0, 0);
    run(2);

    // Halt at word 3, long freeze, restart after reset.
    load_word(3, 32'hFC00_0000);
    pulse_reset();
    run(16);
    pulse_reset();
    run(2);

    // Enable low hold, then a load that also holds the stage.
    load_word(3, 32'h0000_0020);
    pulse_reset();
    run(2);
    repeat (5) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 1, 8'd5, 32'h1234_5678);
    run(6);

    // Address wrap and PC arithmetic wrap.
    drive(0, 1, 0, 0, 0, 1, 32'h0000_0400, 0, 0, 0);
    run(2);
    drive(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    run(2);

    // Random control traffic.
    for (int i = 0; i < 3000; i++) begin
      bt  = ($urandom_range(0, 9) == 0) ? $urandom : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      jt  = ($urandom_range(0, 9) == 0) ? $urandom : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      ldd = ($urandom_range(0, 9) == 0) ? {6'h3f, 26'($urandom)} : rand_plain();
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 19) == 0), bt,
            ($urandom_range(0, 19) == 0), jt, ($urandom_range(0, 19) == 0),
            8'($urandom_range(0, 255)), ldd);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
